// File: rtl/ifetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifetch_ctrl_pkg;

    // Pipeline stall vector: bit 1 is PC/IC, bit 2 is ID.
    localparam int STALL_WD = 6;
    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IF_IDLE = 2'b00,  // nothing outstanding, no word held
        IF_REQ  = 2'b01,  // request driven, waiting for addr_ok
        IF_WAIT = 2'b10,  // request accepted, waiting for data_ok
        IF_DONE = 2'b11   // word held for IC
    } if_state_e;

    // True while a bus transaction is open (request pending or data pending).
    function automatic logic in_flight(input if_state_e s);
        return (s == IF_REQ) || (s == IF_WAIT);
    endfunction

endpackage

// File: rtl/ifetch_ctrl_buf.sv
// One-entry holding register for the fetched instruction word.
module ifetch_ctrl_buf #(
    parameter int DATA_WD = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clr,
    input  logic               hold,
    input  logic [DATA_WD-1:0] d,
    output logic [DATA_WD-1:0] q,
    output logic               valid
);

    // Load wins; clear drops valid unless the consumer is holding the word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the data register is reset too, because the word is a
            // visible output that must read zero straight out of reset.
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            // NOTE: sequential state always uses non-blocking assignment so
            // every flop samples pre-edge values regardless of block order.
            q     <= d;
            valid <= 1'b1;
        end else if (clr && !hold) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch sequencer between PC stage, IC stage and the inst bus.
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 32,
    parameter int PERF_WD = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_WD-1:0] stall,
    input  logic                flush,
    input  logic                br_e,
    input  logic                pc_ce,
    input  logic [ADDR_WD-1:0]  pc_pc,
    output logic                inst_req,
    output logic [ADDR_WD-1:0]  inst_addr,
    input  logic                inst_addr_ok,
    input  logic                inst_data_ok,
    input  logic [DATA_WD-1:0]  inst_rdata,
    output logic                inst_valid,
    output logic [DATA_WD-1:0]  inst_o,
    output logic                stallreq_if,
    output logic [PERF_WD-1:0]  perf_wait_cnt
);

    if_state_e          state_q, state_d;
    logic               cancel_q, cancel_d;
    logic [ADDR_WD-1:0] addr_q;
    logic [PERF_WD-1:0] cnt_q;

    logic kill;
    logic fetch_go;
    logic stall_if;
    logic issue;
    logic req;
    logic buf_load;
    logic stall_raw;

    // Only the PC/IC stall bit matters here; the rest belong to later stages.
    logic unused_stall;
    assign unused_stall = ^{stall[STALL_WD-1:STALL_IF+1], stall[STALL_IF-1:0]};

    assign kill     = flush | br_e;
    assign fetch_go = pc_ce & ~kill;
    assign stall_if = (stall[STALL_IF] == STOP);

    // A new request goes out from IDLE, or from DONE once IC takes the word.
    assign issue = fetch_go &
                   ((state_q == IF_IDLE) || ((state_q == IF_DONE) && !stall_if));

    // Next-state, request and buffer-load decode.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_d  = state_q;
        cancel_d = cancel_q;
        req      = 1'b0;
        buf_load = 1'b0;
        if (issue) begin
            req = 1'b1;
            if (inst_addr_ok && inst_data_ok) begin
                buf_load = 1'b1;
                state_d  = IF_DONE;
            end else if (inst_addr_ok) begin
                state_d = IF_WAIT;
            end else begin
                state_d = IF_REQ;
            end
        end else begin
            unique case (state_q)
                IF_REQ: begin
                    req      = 1'b1;
                    cancel_d = cancel_q | kill;
                    if (inst_addr_ok) begin
                        if (inst_data_ok) begin
                            buf_load = ~(cancel_q | kill);
                            state_d  = (cancel_q | kill) ? IF_IDLE : IF_DONE;
                            cancel_d = 1'b0;
                        end else begin
                            state_d = IF_WAIT;
                        end
                    end
                end
                IF_WAIT: begin
                    cancel_d = cancel_q | kill;
                    if (inst_data_ok) begin
                        buf_load = ~(cancel_q | kill);
                        state_d  = (cancel_q | kill) ? IF_IDLE : IF_DONE;
                        cancel_d = 1'b0;
                    end
                end
                IF_DONE: begin
                    if (kill || !stall_if) begin
                        state_d = IF_IDLE;
                    end
                end
                default: begin
                    state_d = IF_IDLE;
                end
            endcase
        end
    end

    assign stall_raw = in_flight(state_q) |
                       ((state_q == IF_IDLE) & fetch_go & ~(inst_addr_ok & inst_data_ok));

    // Combinational outputs are gated by reset so they drop without a clock.
    assign inst_req    = rst & req;
    assign inst_addr   = !rst ? '0 : (issue ? pc_pc : addr_q);
    assign stallreq_if = rst & stall_raw;

    // State, cancel flag and the address held while the request is pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IF_IDLE;
            cancel_q <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            if (issue) begin
                addr_q <= pc_pc;
            end
        end
    end

    // Saturating count of cycles spent waiting on the fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (stall_raw && (cnt_q != '1)) begin
            cnt_q <= cnt_q + PERF_WD'(1);
        end
    end

    assign perf_wait_cnt = cnt_q;

    ifetch_ctrl_buf #(
        .DATA_WD(DATA_WD)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .load (buf_load),
        .clr  (state_q == IF_DONE),
        .hold (stall_if & ~kill),
        .d    (inst_rdata),
        .q    (inst_o),
        .valid(inst_valid)
    );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_ifetch_ctrl;
    import ifetch_ctrl_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int PW   = 4;
    localparam int PMAX = (1 << PW) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [STALL_WD-1:0] stall;
    logic                flush, br_e, pc_ce;
    logic [AW-1:0]       pc_pc;
    logic                inst_req;
    logic [AW-1:0]       inst_addr;
    logic                inst_addr_ok, inst_data_ok;
    logic [DW-1:0]       inst_rdata;
    logic                inst_valid;
    logic [DW-1:0]       inst_o;
    logic                stallreq_if;
    logic [PW-1:0]       perf_wait_cnt;

    always #5 clk = ~clk;

    ifetch_ctrl #(
        .ADDR_WD(AW),
        .DATA_WD(DW),
        .PERF_WD(PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .br_e         (br_e),
        .pc_ce        (pc_ce),
        .pc_pc        (pc_pc),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .inst_valid   (inst_valid),
        .inst_o       (inst_o),
        .stallreq_if  (stallreq_if),
        .perf_wait_cnt(perf_wait_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks the open transaction and the held word.
    bit          m_req_pend;   // request out, not yet accepted
    bit          m_data_pend;  // accepted, data not yet returned
    bit          m_drop;       // returned data must be discarded
    bit          m_hold_v;     // word held for IC
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_word;
    int          m_cnt;

    task automatic model_reset();
        m_req_pend  = 0;
        m_data_pend = 0;
        m_drop      = 0;
        m_hold_v    = 0;
        m_addr      = '0;
        m_word      = '0;
        m_cnt       = 0;
    endtask

    function automatic bit model_issue(input bit s1, input bit fl, input bit br, input bit ce);
        return !m_req_pend && !m_data_pend && ce && !fl && !br && !(m_hold_v && s1);
    endfunction

    // Values seen on the last step, for scenario-level checks.
    logic          last_req, last_valid, last_stall;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_o;

    // One clock cycle: called at a falling edge, drives inputs, checks all
    // outputs against the model, advances the model, returns at the next falling edge.
    task automatic step(input bit s1, input bit fl, input bit br, input bit ce,
                        input logic [AW-1:0] pc, input bit a, input bit d,
                        input logic [DW-1:0] rd);
        bit            iss, e_req, e_stall;
        logic [AW-1:0] e_addr;
        stall           = '0;
        stall[STALL_IF] = s1;
        stall[STALL_ID] = s1;
        flush        = fl;
        br_e         = br;
        pc_ce        = ce;
        pc_pc        = pc;
        inst_addr_ok = a;
        inst_data_ok = d;
        inst_rdata   = rd;
        #1;
        iss     = model_issue(s1, fl, br, ce);
        e_req   = m_req_pend || iss;
        e_addr  = iss ? pc : m_addr;
        e_stall = m_req_pend || m_data_pend ||
                  (!m_hold_v && ce && !fl && !br && !(a && d));
        check("req",   64'(inst_req),      64'(e_req));
        check("addr",  64'(inst_addr),     64'(e_addr));
        check("valid", 64'(inst_valid),    64'(m_hold_v));
        check("word",  64'(inst_o),        64'(m_word));
        check("stall", 64'(stallreq_if),   64'(e_stall));
        check("cnt",   64'(perf_wait_cnt), 64'(m_cnt));
        last_req   = inst_req;
        last_addr  = inst_addr;
        last_valid = inst_valid;
        last_o     = inst_o;
        last_stall = stallreq_if;
        // advance the model
        if (iss) begin
            m_addr   = pc;
            m_hold_v = 0;
            if (a && d) begin
                m_word   = rd;
                m_hold_v = 1;
            end else if (a) begin
                m_data_pend = 1;
            end else begin
                m_req_pend = 1;
            end
        end else if (m_req_pend) begin
            if (fl || br) m_drop = 1;
            if (a) begin
                m_req_pend = 0;
                if (d) begin
                    if (!m_drop) begin
                        m_word   = rd;
                        m_hold_v = 1;
                    end
                    m_drop = 0;
                end else begin
                    m_data_pend = 1;
                end
            end
        end else if (m_data_pend) begin
            if (fl || br) m_drop = 1;
            if (d) begin
                m_data_pend = 0;
                if (!m_drop) begin
                    m_word   = rd;
                    m_hold_v = 1;
                end
                m_drop = 0;
            end
        end else if (m_hold_v) begin
            if (fl || br || !s1) m_hold_v = 0;
        end
        if (e_stall && m_cnt < PMAX) m_cnt++;
        @(posedge clk);
        @(negedge clk);
    endtask

    int n_req, n_stl;

    initial begin
        bit s1, fl, br, ce, a, d, e_req;
        logic [AW-1:0] pc;

        rst = 1'b0;
        stall = '0; flush = 0; br_e = 0; pc_ce = 0; pc_pc = '0;
        inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_req",   64'(inst_req),      64'(0));
        check("rst_addr",  64'(inst_addr),     64'(0));
        check("rst_valid", 64'(inst_valid),    64'(0));
        check("rst_word",  64'(inst_o),        64'(0));
        check("rst_stall", 64'(stallreq_if),   64'(0));
        check("rst_cnt",   64'(perf_wait_cnt), 64'(0));
        rst = 1'b1;

        // Fetch with addr_ok in the issue cycle, data two cycles later.
        n_req = 0; n_stl = 0;
        step(0, 0, 0, 1, 32'hBFC00000, 1, 0, '0);
        n_req += int'(last_req); n_stl += int'(last_stall);
        check("f1_addr", 64'(last_addr), 64'(32'hBFC00000));
        step(0, 0, 0, 1, 32'hBFC00000, 0, 0, '0);
        n_req += int'(last_req); n_stl += int'(last_stall);
        step(0, 0, 0, 1, 32'hBFC00000, 0, 1, 32'h24080001);
        n_req += int'(last_req); n_stl += int'(last_stall);
        // DONE under IC stall for five cycles.
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 1, 32'hBFC00004, 0, 0, '0);
            if (i == 0) begin
                n_req += int'(last_req); n_stl += int'(last_stall);
                check("f1_req_cycles",   64'(n_req), 64'(1));
                check("f1_stall_cycles", 64'(n_stl), 64'(3));
            end
            check("hold_valid", 64'(last_valid), 64'(1));
            check("hold_word",  64'(last_o),     64'(32'h24080001));
            check("hold_noreq", 64'(last_req),   64'(0));
        end

        // Stall released: request issues from DONE, addr_ok three cycles late.
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 32'hBFC00004 + AW'(8 * i), (i == 3), 0, '0);
            check("dly_req",  64'(last_req),  64'(1));
            check("dly_addr", 64'(last_addr), 64'(32'hBFC00004));
        end

        // Branch redirect in WAIT; returning word is dropped.
        step(0, 0, 1, 1, 32'hBFC00100, 0, 0, '0);
        step(0, 0, 0, 1, 32'hBFC00100, 0, 1, 32'hDEADBEEF);
        check("cancel_stall", 64'(last_stall), 64'(1));
        step(0, 0, 0, 1, 32'hBFC00100, 1, 0, '0);
        check("cancel_valid", 64'(last_valid), 64'(0));
        check("redir_req",    64'(last_req),   64'(1));
        check("redir_addr",   64'(last_addr),  64'(32'hBFC00100));

        // Reset asserted mid-WAIT, between clock edges.
        pc_ce = 1; pc_pc = 32'hBFC00200;
        rst = 1'b0;
        #1;
        check("arst_req",   64'(inst_req),      64'(0));
        check("arst_addr",  64'(inst_addr),     64'(0));
        check("arst_valid", 64'(inst_valid),    64'(0));
        check("arst_word",  64'(inst_o),        64'(0));
        check("arst_stall", 64'(stallreq_if),   64'(0));
        check("arst_cnt",   64'(perf_wait_cnt), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 0, '0, 0, 1, 32'h55AA55AA);   // stray data_ok
        step(0, 0, 0, 0, '0, 0, 0, '0);
        check("stray_valid", 64'(last_valid), 64'(0));
        check("stray_stall", 64'(last_stall), 64'(0));
        step(0, 0, 0, 1, 32'hBFC00300, 1, 1, 32'h12345678);
        step(0, 0, 0, 0, '0, 0, 0, '0);
        check("post_valid", 64'(last_valid), 64'(1));
        check("post_word",  64'(last_o),     64'(32'h12345678));

        // Long addr_ok stall saturates the wait counter.
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 32'hBFC00400, 0, 0, '0);
        check("sat_cnt", 64'(perf_wait_cnt), 64'(PMAX));
        step(0, 0, 0, 1, 32'hBFC00400, 1, 0, '0);
        check("sat_hold", 64'(perf_wait_cnt), 64'(PMAX));
        step(0, 0, 0, 1, 32'hBFC00400, 0, 1, 32'hCAFEF00D);
        step(0, 0, 0, 0, '0, 0, 0, '0);

        // Random traffic with a bus responder that only answers legal requests.
        for (int i = 0; i < 3000; i++) begin
            s1 = ($urandom % 4) == 0;
            fl = ($urandom % 16) == 0;
            br = ($urandom % 12) == 0;
            ce = ($urandom % 4) != 0;
            pc = $urandom & 32'hFFFF_FFFC;
            e_req = m_req_pend || model_issue(s1, fl, br, ce);
            a = e_req && ($urandom % 2 == 0);
            if (m_data_pend)  d = ($urandom % 3) == 0;
            else if (a)       d = ($urandom % 4) == 0;
            else              d = 0;
            step(s1, fl, br, ce, pc, a, d, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
